im_loader: RTL and testbench

Program loader that writes the instruction memory from a byte stream. It accepts a length-prefixed, big-endian byte stream over a valid/ready handshake, assembles 32-bit instruction words, and issues one write per word to consecutive word addresses starting at 0. It sits between the host/boot interface and the instruction memory write port, and holds the CPU off through `busy` until loading completes.

---
 rtl/im_loader_if.sv | 28 ++
 rtl/im_loader.sv | 148 ++++++++++++++
 tb/tb_im_loader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/im_loader_if.sv
// ============================================================================
// im_loader_if : byte-stream input and instruction-memory write port  (rev 1.0)
// ============================================================================
`default_nettype none

interface im_loader_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;

   // master: the loader; slave: the stream source / memory side
   modport master (
      input  in_valid, in_data,
      output in_ready, we, waddr, wdata
   );

   modport slave (
      output in_valid, in_data,
      input  in_ready, we, waddr, wdata
   );
endinterface

`default_nettype wire

// File: rtl/im_loader.sv
// ============================================================================
// im_loader : length-prefixed big-endian byte stream -> instruction memory  (rev 1.0)
// ============================================================================
`default_nettype none

module im_loader #(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 1024
) (
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic        start,
   im_loader_if.master      bus,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [ADDR_W:0]  word_count
);

   localparam int          CW    = ADDR_W + 1;
   localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_HI = 3'd1,
      S_LEN_LO = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            in_ready;
   logic            hs;
   logic [7:0]      len_hi;
   logic [15:0]     len;
   logic [15:0]     n_rx;
   logic [23:0]     asm_word;
   logic [1:0]      byte_idx;
   logic [CW-1:0]   count_nxt;
   logic            count_hit;
   logic            n_zero;
   logic            n_big;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]     wdata;

   assign hs        = bus.in_valid && in_ready;
   assign n_rx      = {len_hi, bus.in_data};
   assign n_zero    = (n_rx == 16'd0);
   assign n_big     = ({1'b0, n_rx} > MAX_N);
   assign count_nxt = word_count + CW'(1);
   assign count_hit = (17'(count_nxt) == {1'b0, len});

   assign busy         = (state != S_IDLE);
   assign bus.we       = (state == S_WRITE);
   assign bus.in_ready = in_ready;
   assign bus.waddr    = waddr;
   assign bus.wdata    = wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // in_ready is a pure function of state, never of in_valid
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nxt = S_LEN_HI;
         end
         S_LEN_HI: begin
            in_ready = 1'b1;
            if (hs) state_nxt = S_LEN_LO;
         end
         S_LEN_LO: begin
            in_ready = 1'b1;
            if (hs) state_nxt = (n_zero || n_big) ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (hs && byte_idx == 2'd3) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            state_nxt = count_hit ? S_IDLE : S_DATA;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_hi     <= '0;
         len        <= '0;
         asm_word   <= '0;
         byte_idx   <= '0;
         word_count <= '0;
         done       <= 1'b0;
         err        <= 1'b0;
         waddr      <= '0;
         wdata      <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  done       <= 1'b0;
                  err        <= 1'b0;
                  word_count <= '0;
               end
            end
            S_LEN_HI: begin
               if (hs) len_hi <= bus.in_data;
            end
            S_LEN_LO: begin
               if (hs) begin
                  len      <= n_rx;
                  byte_idx <= 2'd0;
                  if (n_zero)     done <= 1'b1;
                  else if (n_big) err  <= 1'b1;
               end
            end
            S_DATA: begin
               if (hs) begin
                  asm_word <= {asm_word[15:0], bus.in_data};
                  byte_idx <= byte_idx + 2'd1;
                  // capture the write port on the last byte so WRITE drives registers only
                  if (byte_idx == 2'd3) begin
                     waddr <= word_count[ADDR_W-1:0];
                     wdata <= {asm_word, bus.in_data};
                  end
               end
            end
            S_WRITE: begin
               word_count <= count_nxt;
               if (count_hit) done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// ============================================================================
// tb_im_loader : scoreboard bench for im_loader  (rev 1.0)
// ============================================================================
`default_nettype none

module tb_im_loader;

   localparam int ADDR_W    = 10;
   localparam int MAX_WORDS = 1024;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            busy;
   logic            done;
   logic            err;
   logic [ADDR_W:0] word_count;

   int  checks   = 0;
   int  failures = 0;
   int  cyc      = 0;
   int  last_we  = -1;
   int  last_gap = 0;
   int  next_addr;
   wr_t sb[$];

   im_loader_if #(.ADDR_W(ADDR_W)) bus ();

   im_loader #(
      .ADDR_W    (ADDR_W),
      .MAX_WORDS (MAX_WORDS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // write monitor: every we pulse must match the oldest expected write
   always @(negedge clk) begin
      wr_t e;
      if (rst || !busy) last_we = -1;
      if (!rst && bus.we) begin
         if (sb.size() == 0) begin
            check_value("unexpected_we", 1, 0);
         end else begin
            e = sb.pop_front();
            check_value("waddr", 64'(bus.waddr), 64'(e.addr));
            check_value("wdata", 64'(bus.wdata), 64'(e.data));
         end
         if (last_we >= 0) begin
            last_gap = cyc - last_we;
            check_value("we_gap_min", 64'(last_gap >= 5), 1);
         end
         last_we = cyc;
      end
   end

   task automatic do_start(output int c0);
      start = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      next_addr = 0;
      c0        = cyc;
      check_value("start_busy",  64'(busy), 1);
      check_value("start_ready", 64'(bus.in_ready), 1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall, input bit pulse_start);
      int n = 0;
      for (int i = 0; i < stall; i++) begin
         bus.in_valid = 1'b0;
         @(negedge clk);
      end
      if (stall >= 2) check_value("ready_while_waiting", 64'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      start        = pulse_start;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check_value("ready_timeout", 0, 1);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int stall, input int start_byte);
      wr_t e;
      e.addr = ADDR_W'(next_addr);
      e.data = w;
      sb.push_back(e);
      next_addr++;
      for (int i = 0; i < 4; i++) begin
         logic [31:0] t;
         t = w << (8 * i);
         send_byte(t[31:24], stall, (i == start_byte));
      end
   endtask

   task automatic wait_idle(output int t);
      int n = 0;
      bus.in_valid = 1'b0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_value("busy_timeout", 64'(busy), 0);
      t = cyc;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_value(tag, {bus.in_ready, bus.we, 64'(bus.waddr), bus.wdata, busy, done, err, 64'(word_count)}, 0);
   endtask

   initial begin
      int c0;
      int t_end;
      rst          = 1'b1;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      rst = 1'b0;
      @(negedge clk);

      // basic two-word load, no stalls
      do_start(c0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h02, 0, 1'b0);
      send_word(32'h2008_0005, 0, -1);
      send_word(32'hAC08_0000, 0, -1);
      wait_idle(t_end);
      check_value("basic_latency", 64'(t_end - c0), 12);
      check_value("basic_done",    64'(done), 1);
      check_value("basic_count",   64'(word_count), 2);
      check_value("basic_gap",     64'(last_gap), 5);

      // same stream with 3 idle cycles before every byte
      do_start(c0);
      send_byte(8'h00, 3, 1'b0);
      send_byte(8'h02, 3, 1'b0);
      send_word(32'h2008_0005, 3, -1);
      send_word(32'hAC08_0000, 3, -1);
      wait_idle(t_end);
      check_value("stall_done",  64'(done), 1);
      check_value("stall_count", 64'(word_count), 2);

      // zero length
      do_start(c0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      bus.in_valid = 1'b0;
      check_value("zero_done",  64'(done), 1);
      check_value("zero_busy",  64'(busy), 0);
      check_value("zero_count", 64'(word_count), 0);

      // oversize length is rejected and leftover bytes are not consumed
      do_start(c0);
      check_value("start_clears_done", 64'(done), 0);
      send_byte(8'h04, 0, 1'b0);
      send_byte(8'h01, 0, 1'b0);
      check_value("big_err",   64'(err), 1);
      check_value("big_done",  64'(done), 0);
      check_value("big_busy",  64'(busy), 0);
      bus.in_data = 8'h55;
      repeat (5) @(negedge clk);
      check_value("big_ready", 64'(bus.in_ready), 0);
      bus.in_valid = 1'b0;

      // maximum-length load
      do_start(c0);
      check_value("start_clears_err", 64'(err), 0);
      send_byte(8'h04, 0, 1'b0);
      send_byte(8'h00, 0, 1'b0);
      for (int i = 0; i < MAX_WORDS; i++) send_word($urandom(), 0, -1);
      wait_idle(t_end);
      check_value("full_latency", 64'(t_end - c0), 2 + 5 * MAX_WORDS);
      check_value("full_done",    64'(done), 1);
      check_value("full_count",   64'(word_count), MAX_WORDS);

      // reset in the middle of the second word
      do_start(c0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h02, 0, 1'b0);
      send_word(32'h1234_5678, 0, -1);
      send_byte(8'hDE, 0, 1'b0);
      send_byte(8'hAD, 0, 1'b0);
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check_reset_outputs("midload_reset");
      rst = 1'b0;
      check_value("midload_sb_empty", 64'(sb.size()), 0);
      @(negedge clk);
      do_start(c0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h01, 0, 1'b0);
      send_word(32'hCAFE_F00D, 0, -1);
      wait_idle(t_end);
      check_value("after_reset_done",  64'(done), 1);
      check_value("after_reset_count", 64'(word_count), 1);

      // start pulsed during DATA is ignored
      do_start(c0);
      send_byte(8'h00, 0, 1'b0);
      send_byte(8'h03, 0, 1'b0);
      send_word(32'h0000_0013, 0, -1);
      send_word(32'h0010_0093, 1, 2);
      send_word(32'hFFF0_0113, 0, -1);
      wait_idle(t_end);
      check_value("ign_start_done",  64'(done), 1);
      check_value("ign_start_count", 64'(word_count), 3);

      repeat (3) @(negedge clk);
      check_value("sb_drained", 64'(sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
